// File: rtl/branch_history_table_if.sv
// Fetch/execute connection bundle for the branch direction predictor.
// The pipeline side is the master; the predictor is the slave.
interface branch_history_table_if #(
    parameter int WIDTH      = 32,
    parameter int INDEX_BITS = 6
);
    logic [WIDTH-1:0]      PCF;
    logic                  PCSrcPredF;
    logic [INDEX_BITS-1:0] PHTIndexF;
    logic [INDEX_BITS-1:0] PHTIndexE;
    logic                  BranchOpE;
    logic                  PCSrcResE;

    modport master (
        output PCF,
        output PHTIndexE,
        output BranchOpE,
        output PCSrcResE,
        input  PCSrcPredF,
        input  PHTIndexF
    );

    modport slave (
        input  PCF,
        input  PHTIndexE,
        input  BranchOpE,
        input  PCSrcResE,
        output PCSrcPredF,
        output PHTIndexF
    );
endinterface

// File: rtl/branch_history_table.sv
// Gshare-style direction predictor: 2-bit saturating counters indexed by PC slice XOR
// a non-speculative global history, with same-cycle bypass of the entry being updated.
module branch_history_table #(
    parameter int WIDTH      = 32,
    parameter int INDEX_BITS = 6,
    parameter int GHR_BITS   = 4
) (
    input logic                  clk,
    input logic                  reset,
    branch_history_table_if.slave bus
);
    localparam int ENTRIES = 1 << INDEX_BITS;

    logic [1:0]            r_pht [ENTRIES];
    logic [INDEX_BITS-1:0] w_ghr_ext;
    logic [INDEX_BITS-1:0] w_idx_f;
    logic [1:0]            w_cnt_e;
    logic [1:0]            w_cnt_upd;
    logic                  w_bypass;

    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        if (taken)
            return (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
        else
            return (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
    endfunction

    generate
        if (GHR_BITS == 0) begin : g_no_ghr
            assign w_ghr_ext = '0;
        end else begin : g_ghr
            logic [GHR_BITS-1:0] r_ghr;

            // History only advances on resolved branches, so flushes never need repair.
            if (GHR_BITS == 1) begin : g_ghr1
                always_ff @(posedge clk) begin
                    if (reset)
                        r_ghr <= '0;
                    else if (bus.BranchOpE)
                        r_ghr <= bus.PCSrcResE;
                end
            end else begin : g_ghrn
                always_ff @(posedge clk) begin
                    if (reset)
                        r_ghr <= '0;
                    else if (bus.BranchOpE)
                        r_ghr <= {r_ghr[GHR_BITS-2:0], bus.PCSrcResE};
                end
            end

            assign w_ghr_ext = INDEX_BITS'(r_ghr);
        end
    endgenerate

    assign w_idx_f   = bus.PCF[INDEX_BITS+1:2] ^ w_ghr_ext;
    assign w_cnt_e   = r_pht[bus.PHTIndexE];
    assign w_cnt_upd = sat_update(w_cnt_e, bus.PCSrcResE);

    // Fetch sees the value about to be written when it looks up the entry being trained.
    assign w_bypass       = bus.BranchOpE && (bus.PHTIndexE == w_idx_f);
    assign bus.PHTIndexF  = w_idx_f;
    assign bus.PCSrcPredF = w_bypass ? w_cnt_upd[1] : r_pht[w_idx_f][1];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++)
                r_pht[i] <= 2'b01;
        end else if (bus.BranchOpE) begin
            r_pht[bus.PHTIndexE] <= w_cnt_upd;
        end
    end
endmodule
